// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One spare bit so the counter can represent n itself for any n >= 1.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell of
// the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial n-bit adder, LSB first, one full-adder cell plus a carry flop,
// behind a start/busy/done handshake. Define SERIAL_ADDER_OVF_EN to add V.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] S,
    output logic         Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int             CW   = cnt_width(n);
    localparam logic [CW-1:0]  LAST = CW'(n - 1);

    state_t        state;
    logic [n-1:0]  shA;
    logic [n-1:0]  shB;
    logic [n-1:0]  shS;
    logic          c;
    logic [CW-1:0] cnt;

    logic          sbit;
    logic          co;
    logic [n-1:0]  sum_next;
    logic          last;

    fa_cell u_fa (
        .a  (shA[0]),
        .b  (shB[0]),
        .ci (c),
        .s  (sbit),
        .co (co)
    );

    // Sum bits enter from the MSB side so that after n shifts bit 0 lands at S[0].
    generate
        if (n == 1) begin : g_one
            assign sum_next = sbit;
        end else begin : g_many
            assign sum_next = {sbit, shS[n-1:1]};
        end
    endgenerate

    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            shA   <= '0;
            shB   <= '0;
            shS   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            V     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shA   <= A;
                        shB   <= B;
                        c     <= Cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    shA <= shA >> 1;
                    shB <= shB >> 1;
                    shS <= sum_next;
                    c   <= co;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        S     <= sum_next;
                        Cout  <= co;
`ifdef SERIAL_ADDER_OVF_EN
                        // c is the carry into the MSB, co the carry out of it.
                        V     <= c ^ co;
`endif
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (n=4): directed cases from the test
// plan plus randomized operations against an arithmetic reference model.
module tb_serial_adder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         V;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic int ref_sum(input int a, input int b, input int ci);
        return (a + b + ci) % (1 << N);
    endfunction

    function automatic int ref_cout(input int a, input int b, input int ci);
        return ((a + b + ci) >= (1 << N)) ? 1 : 0;
    endfunction

    function automatic int ref_ovf(input int a, input int b, input int ci);
        int sa, sb, t;
        sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
        sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
        t  = sa + sb + ci;
        return (t > (1 << (N - 1)) - 1 || t < -(1 << (N - 1))) ? 1 : 0;
    endfunction

    task automatic start_op(input int a, input int b, input int ci);
        A     = N'(a);
        B     = N'(b);
        Cin   = ci[0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge; returns cycles until done is seen.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            tick();
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic check_result(input string tag, input int a, input int b, input int ci);
        chk({tag, "_S"}, 32'(S), 32'(ref_sum(a, b, ci)));
        chk({tag, "_Cout"}, 32'(Cout), 32'(ref_cout(a, b, ci)));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_V"}, 32'(V), 32'(ref_ovf(a, b, ci)));
`endif
    endtask

    initial begin
        int lat;
        int ndone;
        int a, b, ci;
        logic [N-1:0] holdS;
        logic         holdC;

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_Cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_V", 32'(V), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // 3 + 5: latency, busy window and done pulse width
        start_op(3, 5, 0);
        wait_done("t1", lat);
        chk("t1_latency", 32'(lat), 32'(N));
        chk("t1_busy_done", 32'(busy), 32'd1);
        chk("t1_S", 32'(S), 32'd8);
        chk("t1_Cout", 32'(Cout), 32'd0);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_pulse", 32'(done), 32'd0);

        // 15 + 1 wraps; result must hold through idle cycles
        start_op(15, 1, 0);
        wait_done("t2", lat);
        chk("t2_S", 32'(S), 32'd0);
        chk("t2_Cout", 32'(Cout), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_S", 32'(S), 32'd0);
            chk("t2_hold_Cout", 32'(Cout), 32'd1);
            chk("t2_idle_done", 32'(done), 32'd0);
        end

        // 7 + 9 + 1 with operands changed during RUN
        start_op(7, 9, 1);
        A = 4'd0; B = 4'd15; Cin = 1'b0;
        tick();
        A = 4'd12; B = 4'd3;
        wait_done("t3", lat);
        chk("t3_S", 32'(S), 32'd1);
        chk("t3_Cout", 32'(Cout), 32'd1);
        tick();

        // 2 + 2 with start pulses while busy at edges 2 and 5
        start_op(2, 2, 0);
        A = 4'd9; B = 4'd9;
        ndone = 0;
        for (int e = 1; e <= 7; e++) begin
            start = (e == 2 || e == 5);
            tick();
            start = 1'b0;
            if (done === 1'b1) ndone++;
        end
        chk("t4_done_count", 32'(ndone), 32'd1);
        chk("t4_S", 32'(S), 32'd4);
        chk("t4_Cout", 32'(Cout), 32'd0);
        chk("t4_no_relaunch", 32'(busy), 32'd0);

        // reset mid-operation discards everything
        start_op(6, 6, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_S", 32'(S), 32'd0);
        chk("t5_Cout", 32'(Cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);
        start_op(1, 1, 0);
        wait_done("t5b", lat);
        chk("t5b_S", 32'(S), 32'd2);
        tick();

`ifdef SERIAL_ADDER_OVF_EN
        start_op(7, 1, 0);
        wait_done("ov1", lat);
        chk("ov1_S", 32'(S), 32'd8);
        chk("ov1_Cout", 32'(Cout), 32'd0);
        chk("ov1_V", 32'(V), 32'd1);
        tick();
        start_op(8, 8, 0);
        wait_done("ov2", lat);
        chk("ov2_S", 32'(S), 32'd0);
        chk("ov2_Cout", 32'(Cout), 32'd1);
        chk("ov2_V", 32'(V), 32'd1);
        tick();
        start_op(3, 2, 0);
        wait_done("ov3", lat);
        chk("ov3_V", 32'(V), 32'd0);
        tick();
`endif

        // randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            a  = int'($urandom_range(0, (1 << N) - 1));
            b  = int'($urandom_range(0, (1 << N) - 1));
            ci = int'($urandom_range(0, 1));
            start_op(a, b, ci);
            A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
            wait_done("rnd", lat);
            chk("rnd_latency", 32'(lat), 32'(N));
            check_result("rnd", a, b, ci);
            holdS = S;
            holdC = Cout;
            tick();
            chk("rnd_done_low", 32'(done), 32'd0);
            chk("rnd_hold_S", 32'(S), 32'(ref_sum(a, b, ci)));
            chk("rnd_hold_Cout", 32'(holdC), 32'(ref_cout(a, b, ci)));
            if (k % 4 == 0) tick();
        end

        // start held high: back-to-back operations every n+2 cycles
        a = 5; b = 6; ci = 1;
        A = N'(a); B = N'(b); Cin = ci[0];
        start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 3 * (N + 2); i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                check_result("b2b", a, b, ci);
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
